// File: rtl/port_b_arbiter_if.sv
// Port B bus bundle: three requesters (video, touchscreen, debug) plus the
// memory port B connection. The arbiter uses the slave view; the requesters
// and memory side use the master view.
interface port_b_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    // Video fetch
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_stall;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    // Touchscreen writer
    logic              ts_req;
    logic              ts_we;
    logic [ADDR_W-1:0] ts_addr;
    logic [DATA_W-1:0] ts_wdata;
    logic              ts_gnt;
    logic              ts_rvalid;
    logic [DATA_W-1:0] ts_rdata;
    // Debug / 7-seg reader
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    // Memory port B
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vid_req, vid_addr,
        output vid_gnt, vid_stall, vid_rvalid, vid_rdata,
        input  ts_req, ts_we, ts_addr, ts_wdata,
        output ts_gnt, ts_rvalid, ts_rdata,
        input  dbg_req, dbg_addr,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output vid_req, vid_addr,
        input  vid_gnt, vid_stall, vid_rvalid, vid_rdata,
        output ts_req, ts_we, ts_addr, ts_wdata,
        input  ts_gnt, ts_rvalid, ts_rdata,
        output dbg_req, dbg_addr,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/port_b_arbiter.sv
// Memory port B arbiter: video has priority, touchscreen and debug share the
// remaining slots round-robin, and a per-requester wait counter lets a
// low-priority request override video once it has waited STARVE_LIMIT cycles.
// Grants are combinational; read data returns one cycle after the grant.
module port_b_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,   // synchronous, active-low
    port_b_arbiter_if.slave    bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_TS, TAG_DBG} tag_t;

    tag_t              tag_q, tag_d;
    logic              rr_q, rr_d;
    logic [CW-1:0]     ts_wait_q, ts_wait_d;
    logic [CW-1:0]     dbg_wait_q, dbg_wait_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] vid_rdata_q, ts_rdata_q, dbg_rdata_q;

    logic gnt_vid, gnt_ts, gnt_dbg;
    logic ts_starved, dbg_starved;
    logic vid_rvalid, ts_rvalid, dbg_rvalid;

    assign ts_starved  = bus.ts_req  && (ts_wait_q  == LIMIT);
    assign dbg_starved = bus.dbg_req && (dbg_wait_q == LIMIT);

    // Grant selection: starved low requester, then video, then round-robin; nothing while in reset
    always_comb begin
        gnt_vid = 1'b0;
        gnt_ts  = 1'b0;
        gnt_dbg = 1'b0;
        if (reset) begin
            if (ts_starved && dbg_starved) begin
                if (rr_q) gnt_dbg = 1'b1;
                else      gnt_ts  = 1'b1;
            end else if (ts_starved) begin
                gnt_ts = 1'b1;
            end else if (dbg_starved) begin
                gnt_dbg = 1'b1;
            end else if (bus.vid_req) begin
                gnt_vid = 1'b1;
            end else if (bus.ts_req && bus.dbg_req) begin
                if (rr_q) gnt_dbg = 1'b1;
                else      gnt_ts  = 1'b1;
            end else if (bus.ts_req) begin
                gnt_ts = 1'b1;
            end else if (bus.dbg_req) begin
                gnt_dbg = 1'b1;
            end
        end
    end

    // Memory port drive for the granted requester; address holds when idle
    always_comb begin
        bus.mem_addr  = addr_q;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (gnt_vid) begin
            bus.mem_addr = bus.vid_addr;
        end else if (gnt_ts) begin
            bus.mem_addr  = bus.ts_addr;
            bus.mem_we    = bus.ts_we;
            bus.mem_wdata = bus.ts_wdata;
        end else if (gnt_dbg) begin
            bus.mem_addr = bus.dbg_addr;
        end
    end

    // Next state: read owner tag, round-robin pointer and saturating wait counters
    always_comb begin
        tag_d = TAG_NONE;
        if (gnt_vid)                 tag_d = TAG_VID;
        else if (gnt_ts && !bus.ts_we) tag_d = TAG_TS;
        else if (gnt_dbg)            tag_d = TAG_DBG;

        rr_d = (gnt_ts || gnt_dbg) ? ~rr_q : rr_q;

        ts_wait_d = ts_wait_q;
        if (!bus.ts_req || gnt_ts)  ts_wait_d = '0;
        else if (ts_wait_q != LIMIT) ts_wait_d = ts_wait_q + 1'b1;

        dbg_wait_d = dbg_wait_q;
        if (!bus.dbg_req || gnt_dbg)  dbg_wait_d = '0;
        else if (dbg_wait_q != LIMIT) dbg_wait_d = dbg_wait_q + 1'b1;
    end

    // Read-return valids follow the owner tag; suppressed while reset is asserted
    assign vid_rvalid = reset && (tag_q == TAG_VID);
    assign ts_rvalid  = reset && (tag_q == TAG_TS);
    assign dbg_rvalid = reset && (tag_q == TAG_DBG);

    // State registers plus per-requester read-data hold registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_q       <= TAG_NONE;
            rr_q        <= 1'b0;
            ts_wait_q   <= '0;
            dbg_wait_q  <= '0;
            addr_q      <= '0;
            vid_rdata_q <= '0;
            ts_rdata_q  <= '0;
            dbg_rdata_q <= '0;
        end else begin
            tag_q      <= tag_d;
            rr_q       <= rr_d;
            ts_wait_q  <= ts_wait_d;
            dbg_wait_q <= dbg_wait_d;
            addr_q     <= bus.mem_addr;
            if (vid_rvalid) vid_rdata_q <= bus.mem_rdata;
            if (ts_rvalid)  ts_rdata_q  <= bus.mem_rdata;
            if (dbg_rvalid) dbg_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.vid_gnt    = gnt_vid;
    assign bus.vid_stall  = bus.vid_req && !gnt_vid && reset;
    assign bus.vid_rvalid = vid_rvalid;
    assign bus.vid_rdata  = vid_rvalid ? bus.mem_rdata : vid_rdata_q;
    assign bus.ts_gnt     = gnt_ts;
    assign bus.ts_rvalid  = ts_rvalid;
    assign bus.ts_rdata   = ts_rvalid ? bus.mem_rdata : ts_rdata_q;
    assign bus.dbg_gnt    = gnt_dbg;
    assign bus.dbg_rvalid = dbg_rvalid;
    assign bus.dbg_rdata  = dbg_rvalid ? bus.mem_rdata : dbg_rdata_q;
endmodule

// File: tb/tb_port_b_arbiter.sv
// Directed bench for port_b_arbiter with a behavioural port B memory
// (synchronous write, 1-cycle registered read).
module tb_port_b_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    port_b_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    port_b_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[15'h0100] = 16'hAAAA;
        mem[15'h0101] = 16'h5555;
        mem[15'h0010] = 16'hBEEF;
        bus.mem_rdata = '0;

        // 1: reset holds off requests, video wins first cycle after release
        reset        = 1'b0;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 15'h0020;
        bus.ts_req   = 1'b1;
        bus.ts_we    = 1'b0;
        bus.ts_addr  = 15'h0030;
        bus.ts_wdata = '0;
        bus.dbg_req  = 1'b0;
        bus.dbg_addr = '0;
        cyc; cyc; #3;
        chk("rst_vid_gnt", 32'(bus.vid_gnt), 32'd0);
        chk("rst_ts_gnt",  32'(bus.ts_gnt),  32'd0);
        chk("rst_mem_we",  32'(bus.mem_we),  32'd0);
        chk("rst_stall",   32'(bus.vid_stall), 32'd0);
        chk("rst_vid_rdata", 32'(bus.vid_rdata), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        cyc; reset = 1'b1; #3;
        chk("rel_vid_gnt", 32'(bus.vid_gnt), 32'd1);
        chk("rel_ts_gnt",  32'(bus.ts_gnt),  32'd0);
        chk("rel_mem_addr", 32'(bus.mem_addr), 32'h0020);
        cyc; bus.vid_req = 1'b0; bus.ts_req = 1'b0;

        // 2: back-to-back video reads
        cyc; bus.vid_req = 1'b1; bus.vid_addr = 15'h0100; #3;
        chk("v2_gnt0", 32'(bus.vid_gnt), 32'd1);
        chk("v2_addr0", 32'(bus.mem_addr), 32'h0100);
        cyc; bus.vid_addr = 15'h0101; #3;
        chk("v2_rvalid1", 32'(bus.vid_rvalid), 32'd1);
        chk("v2_rdata1", 32'(bus.vid_rdata), 32'hAAAA);
        chk("v2_gnt1", 32'(bus.vid_gnt), 32'd1);
        cyc; bus.vid_req = 1'b0; #3;
        chk("v2_rvalid2", 32'(bus.vid_rvalid), 32'd1);
        chk("v2_rdata2", 32'(bus.vid_rdata), 32'h5555);
        cyc; #3;
        chk("v2_rvalid3", 32'(bus.vid_rvalid), 32'd0);
        chk("v2_rdata_hold", 32'(bus.vid_rdata), 32'h5555);
        chk("v2_addr_hold", 32'(bus.mem_addr), 32'h0101);
        chk("v2_we_idle", 32'(bus.mem_we), 32'd0);

        // 3: starvation guard lets the touchscreen write through after 8 waits
        cyc;
        bus.vid_req  = 1'b1; bus.vid_addr = 15'h0200;
        bus.ts_req   = 1'b1; bus.ts_we = 1'b1;
        bus.ts_addr  = 15'h7F00; bus.ts_wdata = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            #3;
            chk($sformatf("st_ts_wait%0d", i), 32'(bus.ts_gnt), 32'd0);
            chk($sformatf("st_vid_gnt%0d", i), 32'(bus.vid_gnt), 32'd1);
            cyc;
        end
        #3;
        chk("st_ts_gnt", 32'(bus.ts_gnt), 32'd1);
        chk("st_vid_gnt", 32'(bus.vid_gnt), 32'd0);
        chk("st_stall", 32'(bus.vid_stall), 32'd1);
        chk("st_we", 32'(bus.mem_we), 32'd1);
        chk("st_addr", 32'(bus.mem_addr), 32'h7F00);
        chk("st_wdata", 32'(bus.mem_wdata), 32'h1234);
        cyc; bus.ts_req = 1'b0; bus.ts_we = 1'b0; #3;
        chk("st_mem", 32'(mem[15'h7F00]), 32'h1234);
        chk("st_no_ts_rvalid", 32'(bus.ts_rvalid), 32'd0);
        chk("st_no_vid_rvalid", 32'(bus.vid_rvalid), 32'd0);
        chk("st_vid_back", 32'(bus.vid_gnt), 32'd1);
        cyc; bus.vid_req = 1'b0;

        // 4: round-robin ts/dbg starting with ts after a fresh reset
        reset = 1'b0;
        cyc; reset = 1'b1;
        bus.ts_req = 1'b1; bus.ts_we = 1'b0; bus.ts_addr = 15'h0100;
        bus.dbg_req = 1'b1; bus.dbg_addr = 15'h0101;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk($sformatf("rr_ts%0d", i),  32'(bus.ts_gnt),  32'((i % 2) == 0));
            chk($sformatf("rr_dbg%0d", i), 32'(bus.dbg_gnt), 32'((i % 2) == 1));
            if (i > 0) begin
                if ((i % 2) == 1) chk($sformatf("rr_ts_data%0d", i), 32'(bus.ts_rdata), 32'hAAAA);
                else              chk($sformatf("rr_dbg_data%0d", i), 32'(bus.dbg_rdata), 32'h5555);
            end
            cyc;
        end
        bus.ts_req = 1'b0; bus.dbg_req = 1'b0;

        // 5: reset right after a debug read grant kills its rvalid
        cyc; bus.dbg_req = 1'b1; bus.dbg_addr = 15'h0010; #3;
        chk("r5_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
        cyc; bus.dbg_req = 1'b0; reset = 1'b0; #3;
        chk("r5_rvalid_in_rst", 32'(bus.dbg_rvalid), 32'd0);
        cyc; reset = 1'b1; #3;
        chk("r5_rvalid_after", 32'(bus.dbg_rvalid), 32'd0);
        chk("r5_rdata_cleared", 32'(bus.dbg_rdata), 32'd0);

        // 6: ts write then immediate dbg read of the same word
        cyc; bus.ts_req = 1'b1; bus.ts_we = 1'b1;
        bus.ts_addr = 15'h0300; bus.ts_wdata = 16'hCAFE; #3;
        chk("w6_ts_gnt", 32'(bus.ts_gnt), 32'd1);
        chk("w6_we", 32'(bus.mem_we), 32'd1);
        cyc; bus.ts_req = 1'b0; bus.ts_we = 1'b0;
        bus.dbg_req = 1'b1; bus.dbg_addr = 15'h0300; #3;
        chk("w6_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
        chk("w6_no_ts_rvalid", 32'(bus.ts_rvalid), 32'd0);
        cyc; bus.dbg_req = 1'b0; #3;
        chk("w6_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        chk("w6_dbg_rdata", 32'(bus.dbg_rdata), 32'hCAFE);
        chk("w6_ts_rvalid", 32'(bus.ts_rvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
